// File: rtl/pwm_decoder.sv
// pwm_decoder: recovers the duty value of a low-then-high PWM waveform of period 2^WIDTH.
// Define PWM_DECODER_SYNC_EN to place a two-flop synchroniser ahead of the edge detector.
module pwm_decoder #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             signal,
    output logic [WIDTH-1:0] value,
    output logic             valid,
    output logic             locked,
    output logic             error
);

    localparam int            CW     = WIDTH + 1;
    localparam logic [CW-1:0] PERIOD = {1'b1, {WIDTH{1'b0}}};
    localparam logic [CW-1:0] ONE    = {{WIDTH{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ACQUIRE,
        LOW,
        HIGH
    } state_t;

    state_t        state;
    logic          s_cur;
    logic          s_prev;
    logic [CW-1:0] low_len;
    logic [CW-1:0] low_cnt;
    logic [CW-1:0] high_cnt;

    logic          fall;
    logic          rise;
    logic [CW-1:0] low_cnt_inc;
    logic [CW-1:0] high_cnt_inc;
    logic [CW-1:0] frame_len;

`ifdef PWM_DECODER_SYNC_EN
    logic sync_a;
    logic sync_b;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
            s_cur  <= 1'b0;
            s_prev <= 1'b0;
        end else begin
            sync_a <= signal;
            sync_b <= sync_a;
            s_cur  <= sync_b;
            s_prev <= s_cur;
        end
    end
`else
    always_ff @(posedge clock) begin
        if (reset) begin
            s_cur  <= 1'b0;
            s_prev <= 1'b0;
        end else begin
            s_cur  <= signal;
            s_prev <= s_cur;
        end
    end
`endif

    always_comb begin
        fall         = s_prev & ~s_cur;
        rise         = ~s_prev & s_cur;
        low_cnt_inc  = low_cnt + ONE;
        high_cnt_inc = high_cnt + ONE;
        frame_len    = low_len + high_cnt;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= ACQUIRE;
            value    <= '0;
            valid    <= 1'b0;
            locked   <= 1'b0;
            error    <= 1'b0;
            low_len  <= '0;
            low_cnt  <= '0;
            high_cnt <= '0;
        end else begin
            valid <= 1'b0;
            error <= 1'b0;
            case (state)
                ACQUIRE: begin
                    if (fall) begin
                        low_cnt <= ONE;
                        state   <= LOW;
                    end else if (s_cur) begin
                        if (high_cnt_inc == PERIOD) begin
                            value    <= '0;
                            valid    <= 1'b1;
                            locked   <= 1'b1;
                            high_cnt <= '0;
                            state    <= HIGH;
                        end else begin
                            high_cnt <= high_cnt_inc;
                        end
                    end else begin
                        high_cnt <= '0;
                    end
                end
                LOW: begin
                    if (rise) begin
                        low_len  <= low_cnt;
                        high_cnt <= ONE;
                        state    <= HIGH;
                    end else if (low_cnt_inc == PERIOD) begin
                        // high_cnt cleared so ACQUIRE starts its high run from a clean count
                        error    <= 1'b1;
                        locked   <= 1'b0;
                        high_cnt <= '0;
                        state    <= ACQUIRE;
                    end else begin
                        low_cnt <= low_cnt_inc;
                    end
                end
                HIGH: begin
                    if (fall) begin
                        if (frame_len == PERIOD) begin
                            value  <= low_len[WIDTH-1:0];
                            valid  <= 1'b1;
                            locked <= 1'b1;
                        end else begin
                            error  <= 1'b1;
                            locked <= 1'b0;
                        end
                        low_cnt <= ONE;
                        state   <= LOW;
                    end else if (high_cnt_inc == PERIOD) begin
                        value    <= '0;
                        valid    <= 1'b1;
                        locked   <= 1'b1;
                        low_len  <= '0;
                        high_cnt <= '0;
                    end else begin
                        high_cnt <= high_cnt_inc;
                    end
                end
                default: state <= ACQUIRE;
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_decoder.sv
// Bench for pwm_decoder: steady-value table, hand corner sequences and a run-length reference model.
module tb_pwm_decoder;

    localparam int W = 4;
    localparam int P = 1 << W;
`ifdef PWM_DECODER_SYNC_EN
    localparam int DEPTH = 3;
`else
    localparam int DEPTH = 1;
`endif

    logic         clock = 1'b0;
    logic         reset;
    logic         signal;
    logic [W-1:0] value;
    logic         valid;
    logic         locked;
    logic         error;

    int checks   = 0;
    int failures = 0;
    int cycle    = 0;
    int gen_cnt  = 0;
    int gen_value = 0;

    // reference model: sample delay line plus run-length bookkeeping
    logic chain [DEPTH];
    logic m_level;
    int   m_run;
    bit   m_initial;
    bit   m_origin_high;
    int   m_credit;
    int   m_value;
    logic m_valid, m_locked, m_error;

    pwm_decoder #(.WIDTH(W)) dut (
        .clock  (clock),
        .reset  (reset),
        .signal (signal),
        .value  (value),
        .valid  (valid),
        .locked (locked),
        .error  (error)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%0d expected=%0d", name, cycle, actual, expected);
        end
    endtask

    task automatic m_fire(input int v);
        m_valid  = 1'b1;
        m_value  = v;
        m_locked = 1'b1;
    endtask

    task automatic m_err();
        m_error  = 1'b1;
        m_locked = 1'b0;
    endtask

    task automatic model_step(input logic s);
        m_valid = 1'b0;
        m_error = 1'b0;
        if (s != m_level) begin
            if (!s) begin
                // a high run of m_run samples just ended
                if (m_origin_high) begin
                    if (m_run < P && m_credit + m_run == P) m_fire(m_credit);
                    else m_err();
                end else if (m_run >= P) begin
                    if (m_run < 2 * P && m_credit + m_run - P == P) m_fire(m_credit);
                    else m_err();
                end
                m_level   = 1'b0;
                m_run     = 1;
                m_initial = 1'b0;
            end else begin
                m_origin_high = !m_initial && m_run < P;
                if (m_origin_high) m_credit = m_run;
                m_level = 1'b1;
                m_run   = 1;
            end
        end else begin
            m_run++;
        end
        if (m_level && (m_run % P) == 0) begin
            m_fire(0);
            if (m_origin_high || m_run >= 2 * P) m_credit = 0;
        end
        if (!m_level && !m_initial && m_run == P) m_err();
    endtask

    task automatic model_edge(input logic v, input logic rst);
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) chain[i] = 1'b0;
            m_level = 1'b0; m_run = 0; m_initial = 1'b1; m_origin_high = 1'b0;
            m_credit = 0; m_value = 0; m_valid = 1'b0; m_locked = 1'b0; m_error = 1'b0;
        end else begin
            model_step(chain[DEPTH-1]);
            for (int unsigned i = DEPTH - 1; i > 0; i--) chain[i] = chain[i-1];
            chain[0] = v;
        end
    endtask

    task automatic tick(input logic v, input logic rst);
        signal = v;
        reset  = rst;
        @(posedge clock);
        #1;
        model_edge(v, rst);
        check("model", int'({value, valid, locked, error}),
              int'({m_value[W-1:0], m_valid, m_locked, m_error}));
        cycle++;
    endtask

    task automatic gen_tick();
        logic v;
        v = (gen_cnt >= gen_value);
        gen_cnt = (gen_cnt + 1) % P;
        tick(v, 1'b0);
    endtask

    task automatic do_reset();
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b1);
        check("reset_state", int'({value, valid, locked, error}), 0);
        gen_cnt = 0;
    endtask

    typedef struct {
        int       gen_value;
        int       periods;
        int       exp_value;
        int       exp_locked;
        int       min_valids;
        int       first_max;
    } vec_t;

    vec_t vecs [5];

    initial begin
        int nvalid, nerr, first, last, err_at;
        bit found;
        signal = 1'b0;
        reset  = 1'b1;
        vecs[0] = '{5, 8, 5, 1, 5, 48};
        vecs[1] = '{0, 8, 0, 1, 5, 17};
        vecs[2] = '{15, 8, 15, 1, 5, 48};
        vecs[3] = '{1, 6, 1, 1, 3, 48};
        vecs[4] = '{10, 6, 10, 1, 3, 48};

        foreach (vecs[i]) begin
            do_reset();
            gen_value = vecs[i].gen_value;
            nvalid = 0; nerr = 0; first = -1; last = -1;
            for (int c = 0; c < vecs[i].periods * P; c++) begin
                gen_tick();
                if (valid) begin
                    if (first < 0) first = c;
                    else check("valid_gap", c - last, P);
                    last = c;
                    nvalid++;
                end
                if (error) nerr++;
            end
            check("steady_value", int'(value), vecs[i].exp_value);
            check("steady_locked", int'(locked), vecs[i].exp_locked);
            check("steady_errors", nerr, 0);
            check("steady_valid_count", int'(nvalid >= vecs[i].min_valids), 1);
            check("first_valid_time",
                  int'(first >= 0 && first <= vecs[i].first_max + DEPTH - 1), 1);
        end

        // duty change 5 -> 9 in the high phase of a period
        do_reset();
        gen_value = 5;
        repeat (4 * P) gen_tick();
        for (int k = 0; k < P && gen_cnt != 10; k++) gen_tick();
        gen_value = 9;
        nerr = 0;
        repeat (2 * P) begin
            gen_tick();
            if (error) nerr++;
        end
        check("change_errors_le1", int'(nerr <= 1), 1);
        check("change_value", int'(value), 9);
        check("change_locked", int'(locked), 1);

        // input stuck low for 20 cycles after lock
        do_reset();
        gen_value = 5;
        repeat (4 * P) gen_tick();
        for (int k = 0; k < P && gen_cnt != 0; k++) gen_tick();
        nerr = 0; err_at = -1;
        for (int k = 0; k < 20; k++) begin
            gen_cnt = (gen_cnt + 1) % P;
            tick(1'b0, 1'b0);
            if (error) begin
                nerr++;
                err_at = k;
            end
        end
        check("stuck_error_count", nerr, 1);
        check("stuck_error_time", err_at, 15 + DEPTH);
        check("stuck_locked", int'(locked), 0);
        check("stuck_value_held", int'(value), 5);
        found = 1'b0;
        for (int k = 0; k < 4 * P && !found; k++) begin
            gen_tick();
            if (valid) found = 1'b1;
        end
        check("stuck_relock", int'(found), 1);
        check("stuck_relock_value", int'(value), 5);
        check("stuck_relock_locked", int'(locked), 1);

        // single-cycle reset while decoding the low phase
        do_reset();
        gen_value = 5;
        repeat (4 * P) gen_tick();
        for (int k = 0; k < P && gen_cnt != 4; k++) gen_tick();
        gen_cnt = (gen_cnt + 1) % P;
        tick(1'b0, 1'b1);
        check("midreset_value", int'(value), 0);
        check("midreset_locked", int'(locked), 0);
        check("midreset_valid", int'(valid), 0);
        found = 1'b0;
        for (int k = 0; k < 2 * P + DEPTH + 2 && !found; k++) begin
            gen_tick();
            if (valid) found = 1'b1;
        end
        check("midreset_relock", int'(found), 1);
        check("midreset_relock_value", int'(value), 5);
        check("midreset_relock_locked", int'(locked), 1);

        // randomized segments checked cycle by cycle against the model
        do_reset();
        for (int seg = 0; seg < 80; seg++) begin
            int kind;
            logic lvl;
            kind = $urandom_range(0, 9);
            if (kind <= 4) begin
                gen_value = $urandom_range(0, P - 1);
                repeat ($urandom_range(P, 4 * P)) gen_tick();
            end else if (kind <= 6) begin
                lvl = 1'($urandom_range(0, 1));
                repeat ($urandom_range(1, 40)) begin
                    gen_cnt = (gen_cnt + 1) % P;
                    tick(lvl, 1'b0);
                end
            end else if (kind <= 8) begin
                repeat ($urandom_range(1, 20)) tick(1'($urandom_range(0, 1)), 1'b0);
            end else begin
                tick(1'b0, 1'b1);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog cycle=%0d actual=timeout required=finish", cycle);
        $fatal(1);
    end

endmodule

// File: doc/pwm_decoder.md
Name: pwm_decoder

Overview:
- Receive-side counterpart of the team's free-running PWM generator.
- Samples a PWM waveform and recovers the duty value that produced it.
- The waveform is low for `value` cycles, then high for the remainder of a 2^WIDTH-cycle period.
- Used for loopback self-test of PWM outputs and for reading PWM-coded signals from sibling boards. Reports recovered value, a per-period strobe, lock status and framing errors.

Parameters:
- WIDTH, 4, duty value width. Period PERIOD = 2^WIDTH clock cycles. Internal run counters are WIDTH+1 bits.

Ports:
- clock  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- signal  input  1  PWM waveform under measurement.
- value  output  WIDTH  last recovered duty value (count of low cycles per period).
- valid  output  1  one-cycle strobe when value is (re)written.
- locked  output  1  high while consecutive well-formed periods are being decoded.
- error  output  1  one-cycle strobe on framing error.

Behaviour:
- Input stage: signal is registered into s_cur; s_prev holds the prior s_cur.
  - Falling edge = s_prev & ~s_cur.
  - Rising edge = ~s_prev & s_cur.
- Reset (synchronous, active-high): state = ACQUIRE; value = 0; valid = 0; locked = 0; error = 0; low_len, low_cnt, high_cnt, s_cur, s_prev = 0.
- ACQUIRE:
  - high_cnt counts consecutive high samples.
  - On falling edge: low_cnt = 1, go to LOW.
  - If high_cnt reaches PERIOD: constant-high period. value = 0, valid pulse, locked = 1, high_cnt = 0, go to HIGH.
- LOW:
  - low_cnt increments each low sample.
  - On rising edge: low_len = low_cnt, high_cnt = 1, go to HIGH.
  - If low_cnt reaches PERIOD with no rising edge: error pulse, locked = 0, go to ACQUIRE. value is held.
- HIGH:
  - high_cnt increments each high sample.
  - On falling edge, if low_len + high_cnt == PERIOD: value = low_len, valid pulse, locked = 1.
  - On falling edge, otherwise: error pulse, locked = 0, value held.
  - On any falling edge: low_cnt = 1, go to LOW.
  - If high_cnt reaches PERIOD with no falling edge: value = 0, valid pulse, locked = 1, low_len = 0, high_cnt = 0, stay in HIGH. This makes a constant-high input repeat valid every PERIOD cycles.
- valid and error are never asserted in the same cycle. Both are single-cycle pulses.
- Latency, pin falling edge to valid: 2 clock edges (one to capture into s_cur, one to update outputs).
- Edge cases:
  - Value PERIOD-1 (low PERIOD-1, high 1) decodes normally.
  - A low run equal to PERIOD is always an error.
  - Arithmetic is WIDTH+1 bits, no wrap.
- Reset mid-operation: any state returns to ACQUIRE on the next edge. Outputs are cleared on that same edge.

Optional Feature:
- Macro: PWM_DECODER_SYNC_EN.
- Defined: two metastability flops precede s_cur. signal may be asynchronous to clock. Latency becomes 4 edges.
- Undefined: signal is sampled directly into s_cur and must be synchronous to clock.
- State machine behaviour is otherwise identical.

Test Plan (WIDTH=4, generator on the same clock, macro undefined unless noted):
- Generator value 5 steady -> valid every 16 cycles after the first full period. value = 5, locked = 1, error never asserted.
- Generator value 0 (constant high) -> first valid within 16 cycles of reset release, then every 16 cycles. value = 0, locked = 1.
- Generator value 15 -> value = 15 every 16 cycles, locked = 1.
- Value changed 5 -> 9 mid-period -> at most one error pulse with locked dropping. Within 2 periods, value = 9 with locked = 1.
- signal held low 20 cycles after lock at value 5 -> error pulse on the 16th low sample. locked = 0, value stays 5. Relock after the generator resumes.
- reset asserted for 1 cycle while in LOW -> next edge: value = 0, locked = 0, valid = 0. Relock with correct value within 2 periods.
- With PWM_DECODER_SYNC_EN defined, repeat the value-5 test -> same values, valid delayed 2 cycles.
